// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM: a binary-encoded state register plus one combinational
// block that produces the next state and the datapath controls.
module mips_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       branch_taken,
  output logic       pc_write_en,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       jump_and_link,
  output logic       is_signed,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [5:0] alu_op,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_FETCH2, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JR, S_HALT
  } state_t;

  localparam logic [5:0] ALU_ADD = 6'h3F;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_write_en   = 1'b0;
    i_or_d        = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    jump_and_link = 1'b0;
    is_signed     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 6'h00;
    halted        = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_FETCH2;
      S_FETCH2: begin
        ir_write    = 1'b1;
        pc_write_en = 1'b1;
        alu_src_b   = 2'b01;
        alu_op      = ALU_ADD;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALU-out.
        alu_src_b = 2'b11;
        is_signed = 1'b1;
        alu_op    = ALU_ADD;
        case (opcode)
          6'h23, 6'h2B: state_d = S_MEM_ADDR;
          6'h00:        state_d = (funct == 6'h08) ? S_JR : S_R_EXEC;
          6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h10: state_d = S_I_EXEC;
          6'h01, 6'h04, 6'h05, 6'h06, 6'h07: state_d = S_BRANCH;
          6'h02, 6'h03: state_d = S_JUMP;
          6'h3F:        state_d = S_HALT;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        is_signed = 1'b1;
        alu_op    = ALU_ADD;
        state_d   = (opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        i_or_d  = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = opcode;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Logical immediates (andi/ori/xori) zero-extend.
        is_signed = !(opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E);
        alu_op    = opcode;
        state_d   = S_I_WB;
      end
      S_I_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        pc_source   = 2'b01;
        pc_write_en = branch_taken;
        alu_op      = opcode;
      end
      S_JUMP: begin
        pc_source     = 2'b10;
        pc_write_en   = 1'b1;
        jump_and_link = (opcode == 6'h03);
      end
      S_JR: begin
        alu_src_a   = 1'b1;
        pc_write_en = 1'b1;
        alu_op      = opcode;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller: walks instruction classes cycle by cycle and
// compares the full control word against hand-derived values.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       branch_taken;
  logic       pc_write_en, i_or_d, mem_write, mem_to_reg, ir_write, reg_dst;
  logic       reg_write, alu_src_a, jump_and_link, is_signed, halted;
  logic [1:0] alu_src_b, pc_source;
  logic [5:0] alu_op;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  mips_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .branch_taken(branch_taken),
    .pc_write_en(pc_write_en), .i_or_d(i_or_d), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .ir_write(ir_write), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .jump_and_link(jump_and_link),
    .is_signed(is_signed), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .halted(halted)
  );

  logic [20:0] obs;
  assign obs = {pc_write_en, i_or_d, mem_write, mem_to_reg, ir_write, reg_dst, reg_write,
                alu_src_a, jump_and_link, is_signed, alu_src_b, pc_source, alu_op, halted};

  function automatic logic [20:0] ev(input logic pwe, iod, mw, mtr, irw, rd, rw, asa,
                                     jal, sg, input logic [1:0] asb, pcs,
                                     input logic [5:0] aop, input logic h);
    return {pwe, iod, mw, mtr, irw, rd, rw, asa, jal, sg, asb, pcs, aop, h};
  endfunction

  task automatic check(input string tag, input logic [20:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one rising edge, then sample on the falling edge.
  task automatic step(input string tag, input logic [20:0] exp);
    @(negedge clk);
    check(tag, exp);
  endtask

  logic [20:0] e_fetch, e_fetch2, e_decode, e_maddr, e_halt;

  initial begin
    e_fetch  = '0;
    e_fetch2 = ev(1,0,0,0,1,0,0,0,0,0,2'b01,2'b00,6'h3F,0);
    e_decode = ev(0,0,0,0,0,0,0,0,0,1,2'b11,2'b00,6'h3F,0);
    e_maddr  = ev(0,0,0,0,0,0,0,1,0,1,2'b10,2'b00,6'h3F,0);
    e_halt   = ev(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,6'h00,1);

    rst = 1'b0; opcode = 6'h00; funct = 6'h20; branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", e_fetch);
    rst = 1'b1;

    // add
    step("r_fetch2", e_fetch2);
    step("r_decode", e_decode);
    step("r_exec", ev(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,6'h00,0));
    step("r_wb", ev(0,0,0,0,0,1,1,0,0,0,2'b00,2'b00,6'h00,0));
    step("r_fetch", e_fetch);

    // lw
    opcode = 6'h23;
    step("lw_fetch2", e_fetch2);
    step("lw_decode", e_decode);
    step("lw_addr", e_maddr);
    step("lw_rd", ev(0,1,0,0,0,0,0,0,0,0,2'b00,2'b00,6'h00,0));
    step("lw_wb", ev(0,0,0,1,0,0,1,0,0,0,2'b00,2'b00,6'h00,0));
    step("lw_fetch", e_fetch);

    // beq taken, then not taken
    opcode = 6'h04; branch_taken = 1'b1;
    step("beq1_fetch2", e_fetch2);
    step("beq1_decode", e_decode);
    step("beq1_branch", ev(1,0,0,0,0,0,0,1,0,0,2'b00,2'b01,6'h04,0));
    step("beq1_fetch", e_fetch);
    branch_taken = 1'b0;
    step("beq0_fetch2", e_fetch2);
    step("beq0_decode", e_decode);
    step("beq0_branch", ev(0,0,0,0,0,0,0,1,0,0,2'b00,2'b01,6'h04,0));
    step("beq0_fetch", e_fetch);

    // jal, then j
    opcode = 6'h03;
    step("jal_fetch2", e_fetch2);
    step("jal_decode", e_decode);
    step("jal_jump", ev(1,0,0,0,0,0,0,0,1,0,2'b00,2'b10,6'h00,0));
    step("jal_fetch", e_fetch);
    opcode = 6'h02;
    step("j_fetch2", e_fetch2);
    step("j_decode", e_decode);
    step("j_jump", ev(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,6'h00,0));
    step("j_fetch", e_fetch);

    // andi (zero-extend), then addiu (sign-extend)
    opcode = 6'h0C;
    step("andi_fetch2", e_fetch2);
    step("andi_decode", e_decode);
    step("andi_exec", ev(0,0,0,0,0,0,0,1,0,0,2'b10,2'b00,6'h0C,0));
    step("andi_wb", ev(0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,6'h00,0));
    step("andi_fetch", e_fetch);
    opcode = 6'h09;
    step("addiu_fetch2", e_fetch2);
    step("addiu_decode", e_decode);
    step("addiu_exec", ev(0,0,0,0,0,0,0,1,0,1,2'b10,2'b00,6'h09,0));
    step("addiu_wb", ev(0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,6'h00,0));

    // jr
    opcode = 6'h00; funct = 6'h08;
    step("jr_fetch", e_fetch);
    step("jr_fetch2", e_fetch2);
    step("jr_decode", e_decode);
    step("jr_exec", ev(1,0,0,0,0,0,0,1,0,0,2'b00,2'b00,6'h00,0));

    // undefined opcode acts as a NOP
    opcode = 6'h3E;
    step("nop_fetch", e_fetch);
    step("nop_fetch2", e_fetch2);
    step("nop_decode", e_decode);
    step("nop_back", e_fetch);

    // sw, interrupted by reset inside MEM_WR
    opcode = 6'h2B;
    step("sw_fetch2", e_fetch2);
    step("sw_decode", e_decode);
    step("sw_addr", e_maddr);
    step("sw_wr", ev(0,1,1,0,0,0,0,0,0,0,2'b00,2'b00,6'h00,0));
    #1 rst = 1'b0;
    #1 check("async_reset", e_fetch);
    @(negedge clk);
    check("reset_hold", e_fetch);
    opcode = 6'h3F;
    rst = 1'b1;
    step("halt_fetch2", e_fetch2);
    step("halt_decode", e_decode);
    for (int i = 0; i < 22; i++) step("halt", e_halt);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/mips_controller.md
MIPS_CONTROLLER -- requirements
Module: mips_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for a 32-bit multicycle MIPS datapath.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single rising-edge clock.
REQ-003 The port rst SHALL be an input, 1 bit wide, and is an asynchronous, active-low reset.
REQ-004 The port opcode SHALL be an input, 6 bits wide, carrying IR[31:26].
REQ-005 The port funct SHALL be an input, 6 bits wide, carrying IR[5:0].
REQ-006 The port branch_taken SHALL be an input, 1 bit wide, carrying the ALU branch compare result.
REQ-007 The port pc_write_en SHALL be an output, 1 bit wide, and is the PC load enable.
REQ-008 The ports i_or_d, mem_write, mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a, jump_and_link and is_signed SHALL each be 1-bit outputs that drive the same-named datapath controls.
REQ-009 The ports alu_src_b and pc_source SHALL each be 2-bit outputs.
REQ-010 The port alu_op SHALL be a 6-bit output.
REQ-011 The port halted SHALL be a 1-bit output that is high while the FSM is in HALT.

Function
REQ-012 Mux select encodings SHALL be:
- alu_src_a: 0=PC, 1=reg A.
- alu_src_b: 00=reg B, 01=4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2.
- pc_source: 00=ALU result, 01=ALU-out register, 10=jump concat.
- reg_dst: 0=rt, 1=rd.
- i_or_d: 0=PC, 1=ALU-out.
REQ-013 alu_op SHALL equal opcode in execute and branch states, and SHALL equal 6'h3F (forced ADD) in FETCH2, DECODE and MEM_ADDR.
REQ-014 The FSM states SHALL be FETCH, FETCH2, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JR, HALT. Every state lasts exactly one cycle except HALT.
REQ-015 In FETCH, all outputs SHALL be 0 (PC is presented to the synchronous memory); the next state SHALL be FETCH2.
REQ-016 FETCH2 SHALL assert ir_write=1 and pc_write_en=1, with alu_src_a=0, alu_src_b=01 and pc_source=00 (PC <= PC+4); the next state SHALL be DECODE.
REQ-017 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and is_signed=1 (ALU-out <= branch target).
REQ-018 The next state from DECODE SHALL be selected by opcode:
- 0x23, 0x2B: MEM_ADDR.
- 0x00 with funct 0x08: JR.
- 0x00 otherwise: R_EXEC.
- 0x09, 0x0A, 0x0B, 0x0C, 0x0D, 0x0E, 0x10: I_EXEC.
- 0x01, 0x04, 0x05, 0x06, 0x07: BRANCH.
- 0x02, 0x03: JUMP.
- 0x3F: HALT.
- any other opcode: FETCH (executed as a NOP).
REQ-019 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and is_signed=1; the next state SHALL be MEM_RD for 0x23 and MEM_WR for 0x2B.
REQ-020 MEM_RD SHALL drive i_or_d=1; the next state SHALL be MEM_WB.
REQ-021 MEM_WB SHALL drive reg_write=1, mem_to_reg=1 and reg_dst=0; the next state SHALL be FETCH.
REQ-022 MEM_WR SHALL drive i_or_d=1 and mem_write=1; the next state SHALL be FETCH.
REQ-023 R_EXEC SHALL drive alu_src_a=1 and alu_src_b=00; the next state SHALL be R_WB, which drives reg_write=1 and reg_dst=1, then returns to FETCH.
REQ-024 I_EXEC SHALL drive alu_src_a=1 and alu_src_b=10, with is_signed=0 for opcodes 0x0C/0x0D/0x0E and is_signed=1 otherwise; the next state SHALL be I_WB, which drives reg_write=1 and reg_dst=0, then returns to FETCH.
REQ-025 BRANCH SHALL drive alu_src_a=1, alu_src_b=00 and pc_source=01, with pc_write_en=branch_taken (the only Mealy output); the next state SHALL be FETCH.
REQ-026 JUMP SHALL drive pc_source=10 and pc_write_en=1, with jump_and_link=1 only for opcode 0x03; the next state SHALL be FETCH.
REQ-027 JR SHALL drive alu_src_a=1, alu_src_b=00, pc_source=00 and pc_write_en=1; the next state SHALL be FETCH.
REQ-028 HALT SHALL be absorbing (all controls 0, halted=1) until reset.
REQ-029 Any output not listed for a state SHALL be 0 in that state.
REQ-030 The state register SHALL use binary encoding; unreachable encodings SHALL transition to FETCH.

Reset
REQ-031 rst=0 SHALL asynchronously force the state to FETCH, so every output reads 0 immediately, including mid-instruction (for example during MEM_WR, mem_write drops without waiting for a clock edge).
REQ-032 After rst rises, the first rising clk edge SHALL move the FSM to FETCH2.

Verification
REQ-033 Deassert reset and hold opcode=0x00, funct=0x20: the state sequence SHALL be FETCH, FETCH2, DECODE, R_EXEC, R_WB, FETCH; reg_write=1 and reg_dst=1 only in R_WB.
REQ-034 Apply opcode=0x23: the FSM SHALL take 6 cycles; i_or_d=1 in MEM_RD; reg_write=1, mem_to_reg=1 and reg_dst=0 in MEM_WB.
REQ-035 Apply opcode=0x04 twice, once with branch_taken=1 and once with branch_taken=0: pc_write_en in BRANCH SHALL be 1 and 0 respectively, with pc_source=01 in both cases.
REQ-036 Apply opcode=0x03: JUMP SHALL show pc_source=10, pc_write_en=1 and jump_and_link=1; opcode=0x02 SHALL show jump_and_link=0.
REQ-037 Apply opcode=0x0C: I_EXEC SHALL show is_signed=0; opcode=0x09 SHALL show is_signed=1.
REQ-038 Assert rst=0 mid-MEM_WR, then apply opcode=0x3F: all outputs SHALL be 0 asynchronously on reset; after restart the FSM SHALL reach HALT with halted=1 and stay there for 20 or more cycles.
